// File: rtl/sync_fifo_fwft_if.sv
// Write/read handshake bundle for sync_fifo_fwft.
// The producer/consumer side uses the master modport; the FIFO uses the slave modport.
interface sync_fifo_fwft_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready,
        input  rd_valid,
        output rd_ready,
        input  rd_data
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready,
        output rd_valid,
        input  rd_ready,
        output rd_data
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO, any depth, registered output stage.
// Latency: push into empty is visible on rd_data the next cycle; wr_ready = !full (no rd_ready path).
module sync_fifo_fwft #(
    parameter  int DATA_WIDTH    = 8,
    parameter  int FIFO_DEPTH    = 8,
    parameter  int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter  int AEMPTY_THRESH = 1,
    localparam int CNT_WIDTH     = $clog2(FIFO_DEPTH + 1),
    localparam int ADDR_WIDTH    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    sync_fifo_fwft_if.slave      bus,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow
);

    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  AFULL_CNT  = CNT_WIDTH'(AFULL_THRESH);
    localparam logic [CNT_WIDTH-1:0]  AEMPTY_CNT = CNT_WIDTH'(AEMPTY_THRESH);
    localparam logic [CNT_WIDTH-1:0]  ONE_CNT    = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_inc;
    logic [ADDR_WIDTH-1:0] rd_ptr_inc;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] head_nxt;
    logic                  overflow_q;
    logic                  push;
    logic                  pop;

    // Status flags are pure decodes of the registered count.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;

    assign bus.wr_ready = !full;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

    assign push = bus.wr_valid && !full;
    assign pop  = rd_valid_q && bus.rd_ready;

    // Non-power-of-two depths need an explicit wrap rather than binary rollover.
    assign wr_ptr_inc = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ONE_ADDR;
    assign rd_ptr_inc = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ONE_ADDR;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + ONE_CNT;
            2'b01:   count_nxt = count_q - ONE_CNT;
            default: count_nxt = count_q;
        endcase
    end

    // The array keeps every stored word, head included; the output register mirrors
    // the head. On a pop the successor comes from the array unless it is the word
    // being written this very cycle, in which case it bypasses from wr_data.
    always_comb begin
        head_nxt = rd_data_q;
        if (pop) begin
            if (count_q > ONE_CNT) begin
                head_nxt = mem[rd_ptr_inc];
            end else if (push) begin
                head_nxt = bus.wr_data;
            end
        end else if (!rd_valid_q && push) begin
            head_nxt = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            count_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_nxt;
            rd_valid_q <= (count_nxt != '0);
            rd_data_q  <= head_nxt;
            if (push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (bus.wr_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed and randomized bench for sync_fifo_fwft (depth 5, 8-bit data) against a queue model.
module tb_sync_fifo_fwft;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;

    sync_fifo_fwft_if #(.DATA_WIDTH(DW)) bus ();

    sync_fifo_fwft #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq[$];
    bit            movf;
    logic [DW-1:0] got[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("wr_ready", 32'(bus.wr_ready), 32'(mq.size() != DEPTH));
        chk("rd_valid", 32'(bus.rd_valid), 32'(mq.size() != 0));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 1));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
        chk("overflow", 32'(overflow), 32'(movf));
        if (mq.size() != 0) begin
            chk("rd_data", 32'(bus.rd_data), 32'(mq[0]));
        end
    endtask

    // One clock: drive inputs, record words the model says are consumed, update model, check.
    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr,
                        input logic fl, input logic rs);
        bit mpush;
        bit mpop;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        flush        = fl;
        rst          = rs;
        mpush = wv && (mq.size() < DEPTH);
        mpop  = rr && (mq.size() > 0);
        if (mpop && !rs && !fl) begin
            got.push_back(bus.rd_data);
        end
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            if (wv && mq.size() == DEPTH) movf = 1'b1;
            if (mpop) void'(mq.pop_front());
            if (mpush) mq.push_back(wd);
        end
        #1;
        check_all();
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        flush        = 1'b0;
        rst          = 1'b1;
        movf         = 1'b0;

        // Reset and idle
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_wr_ready", 32'(bus.wr_ready), 1);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_overflow", 32'(overflow), 0);

        // Fill, partial drain, refill across the wrap point, full drain
        for (int i = 1; i <= 5; i++) begin
            step(1, 8'(i), 0, 0, 0);
            chk("fill_afull", 32'(almost_full), 32'(i >= 4));
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_wr_ready", 32'(bus.wr_ready), 0);
        got.delete();
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
        for (int i = 6; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
        chk("wrap_count", 32'(count), 5);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
        chk("wrap_got_size", 32'(got.size()), 8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_order", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(i + 1));
        end

        // First-word fall-through latency
        step(1, 8'hA5, 0, 0, 0);
        chk("fwft_valid", 32'(bus.rd_valid), 1);
        chk("fwft_data", 32'(bus.rd_data), 32'hA5);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft_empty", 32'(empty), 1);

        // Simultaneous push/pop at count 2
        step(1, 8'h20, 0, 0, 0);
        step(1, 8'h21, 0, 0, 0);
        got.delete();
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h30 + i), 1, 0, 0);
            chk("pp_count", 32'(count), 2);
        end
        chk("pp_first", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 32'h20);
        chk("pp_last", (got.size() == 20) ? 32'(got[19]) : 32'hDEAD, 32'h30 + 17);

        // Full with pop and push together: pop happens, push rejected
        for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
        chk("full_before", 32'(full), 1);
        step(1, 8'hEE, 1, 0, 0);
        chk("fullpp_count", 32'(count), 4);
        chk("fullpp_overflow", 32'(overflow), 1);

        // Flush priority over push and pop
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
        step(1, 8'h77, 1, 1, 0);
        chk("flush_count", 32'(count), 0);
        chk("flush_rd_valid", 32'(bus.rd_valid), 0);
        chk("flush_overflow", 32'(overflow), 0);
        step(1, 8'h33, 0, 0, 0);
        chk("flush_next_data", 32'(bus.rd_data), 32'h33);
        step(0, 8'h00, 1, 0, 0);

        // Reset in the middle of traffic
        for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h48 + i), 1, 0, 0);
        step(1, 8'h99, 1, 0, 1);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
        chk("mid_rst_wr_ready", 32'(bus.wr_ready), 1);
        step(1, 8'h10, 0, 0, 0);
        chk("mid_rst_first", 32'(bus.rd_data), 32'h10);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 149) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, parametrised first-word-fall-through FIFO with valid/ready handshakes on both sides, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a sticky overflow flag. It supports any depth (power of two not required) and any data width. It is the general-purpose buffer for same-clock producer/consumer paths such as bus request queues and pipeline decoupling.

## Interface

- DATA_WIDTH, default 8: width of data words.
- FIFO_DEPTH, default 8: capacity in words; legal range 2 to 1024, any integer.
- AFULL_THRESH, default FIFO_DEPTH-1: almost_full asserts when count >= this value; legal 1 to FIFO_DEPTH.
- AEMPTY_THRESH, default 1: almost_empty asserts when count <= this value; legal 0 to FIFO_DEPTH-1.
- CNT_WIDTH (localparam) = $clog2(FIFO_DEPTH+1); ADDR_WIDTH (localparam) = $clog2(FIFO_DEPTH), minimum 1.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous discard of all contents.
- wr_valid  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- wr_ready  output  1  FIFO can accept a word; equals !full.
- rd_ready  input  1  consumer accepts rd_data.
- rd_valid  output  1  rd_data holds the oldest word.
- rd_data  output  DATA_WIDTH  oldest word (FWFT).
- count  output  CNT_WIDTH  words stored, 0 to FIFO_DEPTH.
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- overflow  output  1  sticky: a write was attempted while full.

## Operation

- Push = wr_valid && wr_ready. Pop = rd_valid && rd_ready.
- wr_ready depends only on registered state, never combinationally on rd_ready. When full, a simultaneous pop does not enable a push in the same cycle.
- count counts every accepted word not yet popped, including the word presented on rd_data. count is next = count + push - pop. A push and a pop together leave count unchanged.
- Storage is a FIFO_DEPTH-entry array plus write and read pointers. Each pointer wraps from FIFO_DEPTH-1 to 0 by explicit compare, not by binary rollover. full and empty derive from count, not from pointer comparison.
- FWFT: rd_data/rd_valid are driven from a registered output stage. After a pop, the next oldest word moves into the output stage in the same clock edge, so back-to-back pops are sustained at one word per cycle.
- Ordering is strict FIFO. No word is duplicated or dropped under any push/pop pattern.
- overflow sets on any cycle with wr_valid && full. It holds until rst or flush. A rejected write does not change any other state.
- flush and rst both clear count, pointers, rd_valid and overflow in one cycle. flush has priority over push/pop in the same cycle. The word offered during a flush cycle is discarded.
- Reset values: wr_ready=1, rd_valid=0, rd_data=0, count=0, full=0, empty=1, almost_full=(AFULL_THRESH==0 ? 1 : 0) (always 0 for legal parameters), almost_empty=1, overflow=0.
- On flush, rd_data holds its last value, but it is don't-care while rd_valid=0.

## Timing

- Write-to-read latency: a push into an empty FIFO at edge N gives rd_valid=1 with that data after edge N, i.e. on the next cycle. There is no combinational path from wr_data to rd_data.
- count, full, empty, almost_full, almost_empty and wr_ready all update on the edge that completes the handshake. The flags are decoded from registered count, with no extra cycle of lag.
- rd_data is stable while rd_valid=1 and rd_ready=0.
- Reset mid-operation: rst asserted in any cycle makes all outputs take their reset values after that edge. Push and pop in that cycle are ignored.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < FIFO_DEPTH.

## Test plan

- Reset/idle (FIFO_DEPTH=5, DATA_WIDTH=8): hold rst 2 cycles -> count=0, empty=1, wr_ready=1, rd_valid=0, rd_data=0x00, almost_empty=1, overflow=0.
- Fill and wrap (FIFO_DEPTH=5): push 0x01..0x05 with rd_ready=0 -> count=5, full=1, wr_ready=0, almost_full=1 from count 4. Then pop 3, push 0x06..0x08 -> pops return 0x01,0x02,0x03, followed by 0x04..0x08 in order, confirming non-power-of-two wrap.
- FWFT latency: push 0xA5 into empty at edge N -> rd_valid=1 with rd_data=0xA5 after edge N. rd_ready=1 on that cycle -> empty=1 next cycle.
- Simultaneous push/pop: with count=2, push and pop every cycle for 20 cycles -> count stays 2 and output order matches input order. When full with rd_ready=1 and wr_valid=1, the pop occurs, the push is rejected, overflow=1, and count=4 next.
- Flush priority: with count=3, assert flush alongside push 0x77 and pop -> next cycle count=0, rd_valid=0, overflow=0. The 0x77 never appears at the output.
- Reset mid-stream: assert rst during back-to-back traffic at count=3 -> all outputs at reset values next cycle. A subsequent push of 0x10 is the first word read.
